// File: rtl/button_debounce_events.sv
// Push-button conditioner: 2-flop synchroniser, bidirectional debounce FSM, clean level plus press/release/long-press pulses.
// Optional long-press detection is built only when BTN_LONG_PRESS_EN is defined.
module button_debounce_events #(
    parameter int unsigned DEBOUNCE_CYCLES   = 50000,
    parameter int unsigned LONG_PRESS_CYCLES = 25000000,
    parameter int unsigned CNT_W             = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inp,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press_pulse
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync_meta;
    logic             s;
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] deb_cnt_next;
    logic             press_next;
    logic             release_next;
    logic             level_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            s         <= 1'b0;
        end else begin
            sync_meta <= inp;
            s         <= sync_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            deb_cnt       <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_next;
            deb_cnt       <= deb_cnt_next;
            btn_level     <= level_next;
            press_pulse   <= press_next;
            release_pulse <= release_next;
        end
    end

    // The entry sample does not count; a level must then survive DEBOUNCE_CYCLES
    // further samples, and a reversal on the completing sample still rejects.
    always_comb begin
        state_next   = state;
        deb_cnt_next = deb_cnt;
        press_next   = 1'b0;
        release_next = 1'b0;
        case (state)
            IDLE: begin
                if (s) begin
                    state_next   = PRESS_WAIT;
                    deb_cnt_next = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_next = IDLE;
                end else if (deb_cnt == DEB_LAST) begin
                    state_next = HELD;
                    press_next = 1'b1;
                end else begin
                    deb_cnt_next = deb_cnt + CNT_ONE;
                end
            end
            HELD: begin
                if (!s) begin
                    state_next   = RELEASE_WAIT;
                    deb_cnt_next = '0;
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_next = HELD;
                end else if (deb_cnt == DEB_LAST) begin
                    state_next   = IDLE;
                    release_next = 1'b1;
                end else begin
                    deb_cnt_next = deb_cnt + CNT_ONE;
                end
            end
            default: begin
                state_next   = IDLE;
                deb_cnt_next = '0;
            end
        endcase
        level_next = (state_next == HELD) || (state_next == RELEASE_WAIT);
    end

`ifdef BTN_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_PRESS_CYCLES);

    logic [CNT_W-1:0] long_cnt;
    logic [CNT_W-1:0] long_cnt_next;
    logic             long_next;

    // Counts only while HELD, so release-bounce time stretches the latency; saturation prevents re-firing.
    always_comb begin
        long_cnt_next = long_cnt;
        long_next     = 1'b0;
        if (press_next) begin
            long_cnt_next = '0;
        end else if ((state == HELD) && (long_cnt != LONG_SAT)) begin
            long_cnt_next = long_cnt + CNT_ONE;
            long_next     = (long_cnt == LONG_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            long_cnt         <= '0;
            long_press_pulse <= 1'b0;
        end else begin
            long_cnt         <= long_cnt_next;
            long_press_pulse <= long_next;
        end
    end
`else
    logic unused_long_cfg;
    assign unused_long_cfg  = (LONG_PRESS_CYCLES > DEBOUNCE_CYCLES);
    assign long_press_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce_events.sv
// Table-driven bench for button_debounce_events: expected pulses are scheduled into a scoreboard
// when each input segment is driven and compared against the DUT every cycle.
`timescale 1ns/1ps
module tb_button_debounce_events;

    localparam int D  = 4;
    localparam int L  = 10;
    localparam int NV = 20;
`ifdef BTN_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    typedef enum int {EV_NONE, EV_PRESS, EV_RELEASE, EV_LONG} ev_t;

    typedef struct {
        logic inp;
        int   hold;
        ev_t  ev;
        int   ev_off;
        int   long_off;
    } vec_t;

    typedef struct {
        ev_t ev;
        int  cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic inp;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_press_pulse;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic exp_level = 1'b0;
    bit   mon_en    = 1'b0;
    vec_t vecs [NV];

    button_debounce_events #(
        .DEBOUNCE_CYCLES  (D),
        .LONG_PRESS_CYCLES(L),
        .CNT_W            (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .inp             (inp),
        .btn_level       (btn_level),
        .press_pulse     (press_pulse),
        .release_pulse   (release_pulse),
        .long_press_pulse(long_press_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: actual %0d required %0d", name, cyc, act, req);
        end
    endtask

    function automatic void push_event(input ev_t ev, input int at);
        int   idx;
        exp_t e;
        idx   = sb.size();
        e.ev  = ev;
        e.cyc = at;
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc > at) begin
                idx = i;
                break;
            end
        end
        sb.insert(idx, e);
    endfunction

    // A segment drives inp at a falling edge; its first sample is the next rising edge,
    // so a pulse D+2 edges later is seen at the falling edge where cyc == t0 + D + 3.
    task automatic apply_stimulus(input vec_t v);
        int t0;
        @(negedge clk);
        t0  = cyc;
        inp = v.inp;
        if (v.ev != EV_NONE) push_event(v.ev, t0 + v.ev_off);
        if ((v.long_off != 0) && LONG_EN) push_event(EV_LONG, t0 + v.long_off);
        repeat (v.hold - 1) @(negedge clk);
    endtask

    always @(negedge clk) begin
        logic [2:0] obs;
        logic [2:0] expv;
        if (mon_en) begin
            obs  = {press_pulse, release_pulse, long_press_pulse};
            expv = 3'b000;
            while ((sb.size() > 0) && (sb[0].cyc <= cyc)) begin
                if (sb[0].cyc < cyc) begin
                    check_output("late_event", sb[0].cyc, cyc);
                end
                case (sb[0].ev)
                    EV_PRESS:   begin expv[2] = 1'b1; exp_level = 1'b1; end
                    EV_RELEASE: begin expv[1] = 1'b1; exp_level = 1'b0; end
                    EV_LONG:    expv[0] = 1'b1;
                    default:    ;
                endcase
                void'(sb.pop_front());
            end
            check_output("pulses", int'(obs), int'(expv));
            check_output("btn_level", int'(btn_level), int'(exp_level));
            check_output("pulse_exclusive", int'($countones(obs) <= 1), 1);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog cycle %0d: actual timeout required finish", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t;
        // {inp, hold, event, event offset, long offset}
        vecs = '{
            '{1'b1, 20, EV_PRESS,   7, 17},
            '{1'b0, 12, EV_RELEASE, 7, 0},
            '{1'b1,  3, EV_NONE,    0, 0},
            '{1'b0,  2, EV_NONE,    0, 0},
            '{1'b1, 20, EV_PRESS,   7, 17},
            '{1'b0,  2, EV_NONE,    0, 0},
            '{1'b1,  2, EV_NONE,    0, 0},
            '{1'b0, 12, EV_RELEASE, 7, 0},
            '{1'b1,  8, EV_PRESS,   7, 0},
            '{1'b0, 12, EV_RELEASE, 7, 0},
            '{1'b1,  4, EV_NONE,    0, 0},
            '{1'b0,  8, EV_NONE,    0, 0},
            '{1'b1,  5, EV_PRESS,   7, 0},
            '{1'b0, 12, EV_RELEASE, 7, 0},
            '{1'b1, 10, EV_PRESS,   7, 0},
            '{1'b0,  2, EV_NONE,    0, 0},
            '{1'b1, 20, EV_NONE,    0, 7},
            '{1'b0, 12, EV_RELEASE, 7, 0},
            '{1'b1, 30, EV_PRESS,   7, 17},
            '{1'b0, 12, EV_RELEASE, 7, 0}
        };

        rst_n = 1'b0;
        inp   = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_btn_level", int'(btn_level), 0);
        check_output("reset_press", int'(press_pulse), 0);
        check_output("reset_release", int'(release_pulse), 0);
        check_output("reset_long", int'(long_press_pulse), 0);
        mon_en = 1'b1;
        rst_n  = 1'b1;

        for (int i = 0; i < NV; i++) apply_stimulus(vecs[i]);

        // Assert reset while press_pulse is high and the button is still held.
        apply_stimulus('{1'b1, 8, EV_PRESS, 7, 0});
        #2;
        rst_n = 1'b0;
        sb.delete();
        exp_level = 1'b0;
        #1;
        check_output("async_reset_level", int'(btn_level), 0);
        check_output("async_reset_press", int'(press_pulse), 0);
        repeat (3) @(negedge clk);
        t     = cyc;
        rst_n = 1'b1;
        push_event(EV_PRESS, t + D + 3);
        if (LONG_EN) push_event(EV_LONG, t + D + 3 + L);
        repeat (19) @(negedge clk);
        apply_stimulus('{1'b0, 12, EV_RELEASE, 7, 0});

        repeat (10) @(negedge clk);
        mon_en = 1'b0;
        check_output("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
